// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB2APB bridge.
//   BRIDGE_WIDTH / BRIDGE_SLAVES : bus width and APB slave count shared by all bridge blocks
//   htrans_t                     : AHB HTRANS encoding
//   resp_state_t                 : AHB response FSM states
//   BRIDGE_BASE_ADDR / SLAVE_WIN_*: bridge memory map, one 64 MB window per slave
package bridge_pkg;

   localparam int unsigned BRIDGE_WIDTH  = 32;
   localparam int unsigned BRIDGE_SLAVES = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      OKAY = 2'b00,
      ERR1 = 2'b01,
      ERR2 = 2'b10
   } resp_state_t;

   localparam logic [31:0] BRIDGE_BASE_ADDR = 32'h8000_0000;
   localparam int unsigned SLAVE_WIN_BITS   = 26;
   localparam logic [31:0] SLAVE_WIN_SIZE   = 32'h0400_0000;

   // Bursts never cross a 1 KB boundary, so only the low bits take part in the increment.
   localparam int unsigned WRAP_BITS = 10;

   function automatic logic [WRAP_BITS-1:0] size_incr(input logic [2:0] hsize);
      logic [WRAP_BITS-1:0] one;
      one = WRAP_BITS'(1);
      return one << hsize;
   endfunction

endpackage

// File: rtl/bridge_addr_decoder.sv
// Combinational address check and APB slave select for the bridge.
//   haddr     : AHB address
//   hsize     : AHB transfer size
//   err_addr  : 1 when the address is outside the bridge map, misaligned, or hsize > word
//   slave_sel : one-hot slave select, all zero when the address is out of range
module bridge_addr_decoder
   import bridge_pkg::*;
#(
   parameter int unsigned       WIDTH     = BRIDGE_WIDTH,
   parameter int unsigned       SLAVES    = BRIDGE_SLAVES,
   parameter logic [WIDTH-1:0]  BASE_ADDR = WIDTH'(BRIDGE_BASE_ADDR)
) (
   input  logic [WIDTH-1:0]  haddr,
   input  logic [2:0]        hsize,
   output logic              err_addr,
   output logic [SLAVES-1:0] slave_sel
);

   localparam int unsigned  SPAN_W = WIDTH + 1;
   // Extra bit keeps the span representable even if the map reaches the top of memory.
   localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(SLAVES) << SLAVE_WIN_BITS;

   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] slave_idx;
   logic             in_range;
   logic             misaligned;

   assign offset    = haddr - BASE_ADDR;
   assign slave_idx = offset >> SLAVE_WIN_BITS;
   assign in_range  = (haddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

   always_comb begin
      misaligned = 1'b0;
      case (hsize)
         3'd0:    misaligned = 1'b0;
         3'd1:    misaligned = haddr[0];
         3'd2:    misaligned = |haddr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   assign err_addr = ~in_range | misaligned;

   for (genvar i = 0; i < SLAVES; i++) begin : g_sel
      assign slave_sel[i] = in_range && (slave_idx == WIDTH'(i));
   end

endmodule

// File: rtl/bridge_ahb_slave_if.sv
// AHB-side front end of the AHB2APB bridge.
//   HCLK, HRESETn             : clock, asynchronous active-low reset
//   HSEL, HREADY_IN, HTRANS,
//   HWRITE, HSIZE, HADDR,
//   HWDATA                    : AHB slave inputs
//   valid                     : qualified, error-free transfer for the APB controller
//   HWRITE_REG, HSIZE_REG     : control captured at the address phase
//   HADDR_REG_D1..D3          : captured address and its 1/2-cycle delayed copies
//   HWDATA_REG                : write data captured in the data phase
//   INC_ADDR                  : next burst address, wrapping within 1 KB
//   flag_*                    : registered one-hot APB slave select
//   HRESP, HREADY_ERR         : two-cycle AHB ERROR response
module bridge_ahb_slave_if
   import bridge_pkg::*;
#(
   parameter int unsigned      WIDTH     = BRIDGE_WIDTH,
   parameter int unsigned      SLAVES    = BRIDGE_SLAVES,
   parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(BRIDGE_BASE_ADDR)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             HSEL,
   input  logic             HREADY_IN,
   input  logic [1:0]       HTRANS,
   input  logic             HWRITE,
   input  logic [2:0]       HSIZE,
   input  logic [WIDTH-1:0] HADDR,
   input  logic [WIDTH-1:0] HWDATA,
   output logic             valid,
   output logic             HWRITE_REG,
   output logic [2:0]       HSIZE_REG,
   output logic [WIDTH-1:0] HADDR_REG_D1,
   output logic [WIDTH-1:0] HADDR_REG_D2,
   output logic [WIDTH-1:0] HADDR_REG_D3,
   output logic [WIDTH-1:0] HWDATA_REG,
   output logic [WIDTH-1:0] INC_ADDR,
   output logic             flag_timer,
   output logic             flag_interruptc,
   output logic             flag_remap_pause_controller,
   output logic             flag_slave4,
   output logic             HRESP,
   output logic             HREADY_ERR
);

   htrans_t           trans;
   logic              active_trans;
   logic              addr_phase;
   logic              err_addr;
   logic [SLAVES-1:0] slave_sel;
   logic [SLAVES-1:0] slave_sel_q;
   logic              wr_phase_q;
   logic              inc_pend_q;
   logic [WIDTH-1:0]  inc_next;
   resp_state_t       state_q, state_d;

   bridge_addr_decoder #(
      .WIDTH     (WIDTH),
      .SLAVES    (SLAVES),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_decoder (
      .haddr     (HADDR),
      .hsize     (HSIZE),
      .err_addr  (err_addr),
      .slave_sel (slave_sel)
   );

   assign trans        = htrans_t'(HTRANS);
   assign active_trans = (trans == NONSEQ) || (trans == SEQ);

   // ERR1 drives HREADY low, so nothing can legitimately be sampled during it.
   assign addr_phase = HSEL & HREADY_IN & active_trans & (state_q != ERR1);
   assign valid      = addr_phase & ~err_addr;

   assign inc_next = {HADDR_REG_D1[WIDTH-1:WRAP_BITS],
                      HADDR_REG_D1[WRAP_BITS-1:0] + size_incr(HSIZE_REG)};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         HADDR_REG_D1 <= '0;
         HADDR_REG_D2 <= '0;
         HADDR_REG_D3 <= '0;
         HWRITE_REG   <= 1'b0;
         HSIZE_REG    <= 3'd0;
         slave_sel_q  <= '0;
         wr_phase_q   <= 1'b0;
         inc_pend_q   <= 1'b0;
         HWDATA_REG   <= '0;
         INC_ADDR     <= '0;
      end else begin
         HADDR_REG_D2 <= HADDR_REG_D1;
         HADDR_REG_D3 <= HADDR_REG_D2;
         if (addr_phase) begin
            HADDR_REG_D1 <= HADDR;
            HWRITE_REG   <= HWRITE;
            HSIZE_REG    <= HSIZE;
            slave_sel_q  <= err_addr ? '0 : slave_sel;
         end
         wr_phase_q <= valid & HWRITE;
         inc_pend_q <= addr_phase;
         if (wr_phase_q) begin
            HWDATA_REG <= HWDATA;
         end
         // D1/HSIZE_REG are only valid the cycle after capture, hence the pending flag.
         if (inc_pend_q) begin
            INC_ADDR <= inc_next;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= OKAY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      HRESP      = 1'b0;
      HREADY_ERR = 1'b1;
      case (state_q)
         OKAY: begin
            if (addr_phase && err_addr) begin
               state_d = ERR1;
            end
         end
         ERR1: begin
            HRESP      = 1'b1;
            HREADY_ERR = 1'b0;
            state_d    = ERR2;
         end
         ERR2: begin
            HRESP   = 1'b1;
            state_d = (addr_phase && err_addr) ? ERR1 : OKAY;
         end
         default: begin
            state_d = OKAY;
         end
      endcase
   end

   assign flag_timer                  = slave_sel_q[0];
   assign flag_interruptc             = slave_sel_q[1];
   assign flag_remap_pause_controller = slave_sel_q[2];
   assign flag_slave4                 = slave_sel_q[3];

endmodule

// File: doc/bridge_ahb_slave_if.md
Name: bridge_ahb_slave_if

Overview:
AHB-side front end of the AHB2APB bridge; sits directly upstream of the bridge APB controller.
- Qualifies AHB transfers into `valid`.
- Registers address, write data and control, and produces the delayed address copies the APB controller uses for PADDR.
- Decodes the APB slave select flags.
- Computes the next burst address.
- Generates the two-cycle AHB ERROR response for unmapped or misaligned accesses.

Parameters:
- WIDTH, 32, data/address width (shared `WIDTH)
- SLAVES, 4, number of APB slaves (shared `SLAVES)
- BASE_ADDR, 32'h8000_0000, bridge base address; each slave gets a 64 MB window above it

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  bridge selected by AHB decoder
- HREADY_IN  in  1  bus HREADY (previous transfer completing)
- HTRANS  in  2  transfer type
- HWRITE  in  1  write=1
- HSIZE  in  3  transfer size
- HADDR  in  WIDTH  address
- HWDATA  in  WIDTH  write data
- valid  out  1  qualified transfer to the APB controller
- HWRITE_REG  out  1  HWRITE registered at the address phase
- HSIZE_REG  out  3  HSIZE registered at the address phase
- HADDR_REG_D1  out  WIDTH  address, 1 cycle after the address phase
- HADDR_REG_D2  out  WIDTH  address, 2 cycles after the address phase
- HADDR_REG_D3  out  WIDTH  address, 3 cycles after the address phase
- HWDATA_REG  out  WIDTH  HWDATA captured in the data phase
- INC_ADDR  out  WIDTH  predicted next burst address
- flag_timer  out  1  decoded select, slave 0
- flag_interruptc  out  1  decoded select, slave 1
- flag_remap_pause_controller  out  1  decoded select, slave 2
- flag_slave4  out  1  decoded select, slave 3
- HRESP  out  1  0=OKAY, 1=ERROR
- HREADY_ERR  out  1  HREADY contribution during an error response; 1 otherwise

Behaviour:
- Reset (HRESETn=0, async): all registered outputs 0, except HREADY_ERR=1; resp FSM=OKAY.
- Combinational `valid` = HSEL & HREADY_IN & HTRANS[1] & ~err_addr.
  - HTRANS[1] covers NONSEQ (10) and SEQ (11).
  - IDLE (00) and BUSY (01) give valid=0.
- err_addr (combinational): either of
  - HADDR outside [BASE_ADDR, BASE_ADDR+256MB);
  - misaligned: HSIZE=1 with HADDR[0]≠0, or HSIZE=2 with HADDR[1:0]≠0.
  - HSIZE>2 is also an error.
- Address-phase capture: on a cycle with HSEL & HREADY_IN & HTRANS[1], register HADDR into HADDR_REG_D1, and HWRITE/HSIZE into HWRITE_REG/HSIZE_REG.
  - HADDR_REG_D1, D2, D3 form a free-running shift pipe: D2<=D1 and D3<=D2 every cycle.
  - D1 holds its value when there is no capture.
- HWDATA_REG: loaded from HWDATA in the cycle after a write address phase (the data phase), held otherwise.
- Flags: registered one-hot decode of HADDR[27:26] at capture.
  - 00=timer, 01=interruptc, 10=remap_pause, 11=slave4.
  - Flags hold until the next capture.
  - All flags are forced to 0 on an error capture.
- INC_ADDR = HADDR_REG_D1 + (1<<HSIZE_REG), registered in the cycle after capture.
  - Wraps within the 1 KB boundary: bits [9:0] increment modulo 1024; bits [31:10] are unchanged.
- Response FSM, states OKAY, ERR1, ERR2:
  - OKAY → ERR1 when HSEL & HREADY_IN & HTRANS[1] & err_addr.
  - ERR1: HRESP=1, HREADY_ERR=0; → ERR2 unconditionally.
  - ERR2: HRESP=1, HREADY_ERR=1; → OKAY, or → ERR1 if a new erroneous transfer is sampled in this cycle.
  - valid=0 throughout ERR1.
  - Transfers arriving in ERR2 with no error are captured normally.
- Simultaneous events:
  - BUSY in mid-burst: no capture; INC_ADDR is held.
  - HREADY_IN=0: no capture, all registers hold, except the D2/D3 shift.
- Reset mid-error: FSM returns to OKAY; HRESP=0 immediately (async).

Decomposition:
- Shared package bridge_pkg:
  - `WIDTH` and `SLAVES` constants
  - htrans_t enum {IDLE, BUSY, NONSEQ, SEQ}
  - resp_state_t enum {OKAY, ERR1, ERR2}
  - BASE_ADDR and the slave window constants
- One sub-module: bridge_addr_decoder — combinational range/alignment check plus one-hot select, instantiated once.

Test Plan:
- Reset: assert HRESETn=0 mid-traffic → all outputs 0, HREADY_ERR=1, HRESP=0.
- Write to timer: NONSEQ write, HADDR=32'h8000_0010, HSIZE=2, HWDATA=32'hDEAD_BEEF in the data phase → valid=1 in the address cycle; next cycle HADDR_REG_D1=32'h8000_0010 and flag_timer=1; HWDATA_REG=32'hDEAD_BEEF; D3 equals the address 3 cycles after capture.
- INCR4 read burst: reads from 32'h8C00_0000, HSIZE=2 → flag_slave4=1; INC_ADDR=32'h8C00_0004, then 08, 0C. An inserted BUSY gives valid=0 and no INC_ADDR change.
- 1 KB wrap: SEQ at 32'h8400_03FC, HSIZE=2 → INC_ADDR=32'h8400_0000, flag_interruptc=1.
- Unmapped address: NONSEQ at 32'h9000_0000 → valid=0, then ERR1 (HRESP=1, HREADY_ERR=0), then ERR2 (HRESP=1, HREADY_ERR=1), then OKAY; all flags 0.
- Misaligned access: HSIZE=1, HADDR=32'h8800_0001 → two-cycle ERROR. A back-to-back valid write in ERR2 is captured, with flag_remap_pause_controller=1 for HADDR=32'h8800_0004.
